pipe_out_fifo: RTL and testbench

PIPE_OUT_FIFO -- requirements
Module: pipe_out_fifo

---
 rtl/pipe_out_fifo.sv | 84 ++++++++
 tb/tb_pipe_out_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_out_fifo.sv
// Purpose: output-side pipeline FIFO, a circular buffer between a producer stage and its consumer.
// Latency: 1 cycle minimum; a pushed word appears on the output after its write edge, never in the same cycle (no fall-through).
// Backpressure: input_rdy drops only when full and ignores output_rdy in that cycle; output_valid is high when the FIFO is non-empty.
//
// Ports:
//   clk_i, reset_i             - clock and synchronous active-high reset
//   input_val/valid/rdy        - upstream write side (valid-ready)
//   output_val/valid/rdy       - downstream read side (valid-ready), output_val is the head word
//   level                      - current occupancy 0..DEPTH
//   beat_count                 - number of words accepted since reset, wraps at 16 bits
module pipe_out_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [WIDTH-1:0]           input_val,
    input  logic                       input_valid,
    output logic                       input_rdy,
    output logic [WIDTH-1:0]           output_val,
    output logic                       output_valid,
    input  logic                       output_rdy,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                beat_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic [15:0]      beat_q;

    logic push;
    logic pop;

    // Handshake flags come only from the registered occupancy, so input_rdy
    // never has a combinational path from output_rdy (a pop at full frees a
    // slot only from the next cycle).
    assign input_rdy    = (level_q != LW'(DEPTH));
    assign output_valid = (level_q != '0);

    assign push = input_valid && input_rdy;
    assign pop  = output_valid && output_rdy;

    assign output_val = mem[rd_ptr];
    assign level      = level_q;
    assign beat_count = beat_q;

    // Storage carries no reset; stale words are unreachable once the pointers
    // and level are cleared.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= input_val;
        end
    end

    // DEPTH is a power of two, so the pointers wrap from DEPTH-1 to 0 by
    // plain overflow.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            beat_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                beat_q <= beat_q + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_out_fifo.sv
// Purpose: self-checking bench for pipe_out_fifo using a directed vector table plus hand-written corner sequences.
// Latency: each vector drives inputs at the falling edge and checks outputs 1 time unit after the next rising edge.
// Backpressure: output_rdy/input_valid are driven per vector; combinational-path checks are done between edges.
module tb_pipe_out_fifo;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [4:0]  input_val;
    logic        input_valid;
    logic        input_rdy;
    logic [4:0]  output_val;
    logic        output_valid;
    logic        output_rdy;
    logic [2:0]  level;
    logic [15:0] beat_count;

    int checks = 0;
    int errors = 0;

    pipe_out_fifo #(.WIDTH(5), .DEPTH(4)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .input_val    (input_val),
        .input_valid  (input_valid),
        .input_rdy    (input_rdy),
        .output_val   (output_val),
        .output_valid (output_valid),
        .output_rdy   (output_rdy),
        .level        (level),
        .beat_count   (beat_count)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  ival;
        logic        ordy;
        logic        e_irdy;
        logic        e_ov;
        logic [4:0]  e_val;
        logic [2:0]  e_lvl;
        logic [15:0] e_beat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic iv, input logic [4:0] ival,
                                input logic ordy, input logic e_irdy, input logic e_ov,
                                input logic [4:0] e_val, input logic [2:0] e_lvl,
                                input logic [15:0] e_beat);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ival = ival; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_val = e_val;
        v.e_lvl = e_lvl; v.e_beat = e_beat;
        vecs.push_back(v);
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic check_outputs(input string tag, input vec_t v);
        chk({tag, " input_rdy"},    32'(input_rdy),    32'(v.e_irdy));
        chk({tag, " output_valid"}, 32'(output_valid), 32'(v.e_ov));
        chk({tag, " level"},        32'(level),        32'(v.e_lvl));
        chk({tag, " beat_count"},   32'(beat_count),   32'(v.e_beat));
        if (v.e_ov) begin
            chk({tag, " output_val"}, 32'(output_val), 32'(v.e_val));
        end
    endtask

    initial begin
        reset_i     = 1'b1;
        input_valid = 1'b0;
        input_val   = '0;
        output_rdy  = 1'b0;

        //   rst iv  ival  ordy irdy ov  val  lvl beat
        // Reset state
        add(1, 0, 5'd0,  0,   1,   0, 5'd0, 0, 0);
        // Single word
        add(0, 1, 5'd7,  0,   1,   1, 5'd7, 1, 1);
        // Clear, then fill 1..4 with output blocked
        add(1, 0, 5'd0,  0,   1,   0, 5'd0, 0, 0);
        add(0, 1, 5'd1,  0,   1,   1, 5'd1, 1, 1);
        add(0, 1, 5'd2,  0,   1,   1, 5'd1, 2, 2);
        add(0, 1, 5'd3,  0,   1,   1, 5'd1, 3, 3);
        add(0, 1, 5'd4,  0,   0,   1, 5'd1, 4, 4);
        // Offered 9 at full is refused for two cycles
        add(0, 1, 5'd9,  0,   0,   1, 5'd1, 4, 4);
        add(0, 1, 5'd9,  0,   0,   1, 5'd1, 4, 4);
        // Drain in order
        add(0, 0, 5'd0,  1,   1,   1, 5'd2, 3, 4);
        add(0, 0, 5'd0,  1,   1,   1, 5'd3, 2, 4);
        add(0, 0, 5'd0,  1,   1,   1, 5'd4, 1, 4);
        add(0, 0, 5'd0,  1,   1,   0, 5'd0, 0, 4);
        // output_rdy on empty changes nothing
        add(0, 0, 5'd0,  1,   1,   0, 5'd0, 0, 4);
        // Streaming: prefill 20, then 0..9 with both sides open
        add(0, 1, 5'd20, 0,   1,   1, 5'd20, 1, 5);
        for (int k = 0; k < 10; k++) begin
            add(0, 1, 5'(k), 1, 1, 1, 5'(k), 1, 16'(6 + k));
        end
        add(0, 0, 5'd0,  1,   1,   0, 5'd0, 0, 15);
        // Full with simultaneous pop
        add(0, 1, 5'd11, 0,   1,   1, 5'd11, 1, 16);
        add(0, 1, 5'd12, 0,   1,   1, 5'd11, 2, 17);
        add(0, 1, 5'd13, 0,   1,   1, 5'd11, 3, 18);
        add(0, 1, 5'd14, 0,   0,   1, 5'd11, 4, 19);
        add(0, 1, 5'd15, 1,   1,   1, 5'd12, 3, 19);
        add(0, 1, 5'd15, 0,   0,   1, 5'd12, 4, 20);
        // Down to level 2, then reset with push and pop requested
        add(0, 0, 5'd0,  1,   1,   1, 5'd13, 3, 20);
        add(0, 0, 5'd0,  1,   1,   1, 5'd14, 2, 20);
        add(1, 1, 5'd30, 1,   1,   0, 5'd0, 0, 0);
        // First word after reset is the new one, not a stale entry
        add(0, 1, 5'd25, 0,   1,   1, 5'd25, 1, 1);

        foreach (vecs[i]) begin
            @(negedge clk_i);
            reset_i     = vecs[i].rst;
            input_valid = vecs[i].iv;
            input_val   = vecs[i].ival;
            output_rdy  = vecs[i].ordy;
            @(posedge clk_i);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i]);
        end

        // Fill to full from level 1 (head 25)
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            input_valid = 1'b1;
            input_val   = 5'(26 + k);
            output_rdy  = 1'b0;
            @(posedge clk_i);
            #1;
        end
        chk("full level", 32'(level), 32'd4);

        // At full, raising output_rdy mid-cycle must not raise input_rdy
        @(negedge clk_i);
        input_valid = 1'b1;
        input_val   = 5'd31;
        output_rdy  = 1'b0;
        #1;
        chk("full input_rdy ordy0", 32'(input_rdy), 32'd0);
        output_rdy = 1'b1;
        #1;
        chk("full input_rdy ordy1", 32'(input_rdy), 32'd0);
        @(posedge clk_i);
        #1;
        chk("pop at full level", 32'(level), 32'd3);
        chk("pop at full input_rdy", 32'(input_rdy), 32'd1);
        chk("pop at full head", 32'(output_val), 32'd26);

        // No fall-through: a word written into an empty FIFO is not visible before its edge
        @(negedge clk_i);
        reset_i     = 1'b1;
        input_valid = 1'b0;
        output_rdy  = 1'b0;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        reset_i     = 1'b0;
        input_valid = 1'b1;
        input_val   = 5'd3;
        #1;
        chk("no fall-through valid", 32'(output_valid), 32'd0);
        @(posedge clk_i);
        #1;
        chk("after write valid", 32'(output_valid), 32'd1);
        chk("after write val", 32'(output_val), 32'd3);
        @(negedge clk_i);
        input_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
